// File: rtl/lut_pkg.sv
// lut_pkg: shared widths and loader state encoding for the line-instruction LUT.
package lut_pkg;
    localparam int LUT_ADDR_W = 8;
    localparam int LUT_DATA_W = 16;
    localparam int BYTE_W     = 8;
    typedef enum logic [1:0] {IDLE, LOAD_HI, LOAD_LO, DONE} load_state_t;
endpackage

// File: rtl/lut_loader_if.sv
// lut_loader_if: byte-stream load port, session status and LUT read port.
interface lut_loader_if;
    import lut_pkg::*;
    logic                  start;
    logic [BYTE_W-1:0]     wr_byte;
    logic                  wr_valid;
    logic                  wr_last;
    logic                  wr_ready;
    logic                  load_busy;
    logic                  load_done;
    logic [LUT_ADDR_W:0]   load_count;
    logic [LUT_ADDR_W-1:0] lut_addr;
    logic [LUT_DATA_W-1:0] lut_out;
    modport master (
        output start, wr_byte, wr_valid, wr_last, lut_addr,
        input  wr_ready, load_busy, load_done, load_count, lut_out
    );
    modport slave (
        input  start, wr_byte, wr_valid, wr_last, lut_addr,
        output wr_ready, load_busy, load_done, load_count, lut_out
    );
endinterface

// File: rtl/lut_ram.sv
// lut_ram: table with one synchronous write port and one combinational read port.
module lut_ram
    import lut_pkg::*;
#(
    parameter int AW = LUT_ADDR_W,
    parameter int DW = LUT_DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] r_mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end
    assign rdata = r_mem[raddr];
endmodule

// File: rtl/lut_loader.sv
// lut_loader: packs a hi/lo byte stream into LUT entries at auto-incrementing addresses.
module lut_loader
    import lut_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    lut_loader_if.slave  bus
);
    load_state_t           r_state;
    logic [LUT_ADDR_W-1:0] r_ptr;
    logic [BYTE_W-1:0]     r_hi;
    logic [LUT_ADDR_W:0]   r_count;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_accept;
    logic                  w_we;
    logic                  w_end;
    assign w_accept = bus.wr_valid && r_ready;
    // start and reset both win over a byte accepted on the same edge
    assign w_we  = w_accept && r_state == LOAD_LO && !bus.start && !reset;
    assign w_end = bus.wr_last || r_ptr == '1;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_hi    <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.start) begin
            r_state <= LOAD_HI;
            r_ptr   <= '0;
            r_hi    <= '0;
            r_count <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else if (w_accept && r_state == LOAD_HI) begin
            r_hi    <= bus.wr_byte;
            r_state <= LOAD_LO;
        end else if (w_accept && r_state == LOAD_LO) begin
            r_ptr   <= r_ptr + 1'b1;
            r_count <= r_count + 1'b1;
            r_state <= w_end ? DONE : LOAD_HI;
            r_ready <= !w_end;
            r_busy  <= !w_end;
            r_done  <= w_end;
        end
    end
    assign bus.wr_ready   = r_ready;
    assign bus.load_busy  = r_busy;
    assign bus.load_done  = r_done;
    assign bus.load_count = r_count;
    lut_ram u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (r_ptr),
        .wdata ({r_hi, bus.wr_byte}),
        .raddr (bus.lut_addr),
        .rdata (bus.lut_out)
    );
endmodule

// File: tb/tb_lut_loader.sv
// tb_lut_loader: directed sessions; a monitor scores load_count on each load_done rise.
module tb_lut_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    lut_loader_if bus();
    lut_loader dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [8:0] cnt_q[$];
    bit mon_en = 1'b0;
    bit idle_in = 1'b0;
    logic [8:0] prev_cnt = '0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // a cycle with no valid byte, start or reset must never move load_count
    always @(posedge clk) idle_in = !bus.wr_valid && !bus.start && !reset;
    always @(negedge clk) begin
        if (mon_en) begin
            if (idle_in) chk("count_hold_without_valid", 32'(bus.load_count), 32'(prev_cnt));
            if (bus.load_done && !prev_done) begin
                if (cnt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got load_done=1 expected no session end");
                end else chk("done_count", 32'(bus.load_count), 32'(cnt_q.pop_front()));
            end
        end
        prev_cnt = bus.load_count;
        prev_done = bus.load_done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        int n = 0;
        bus.wr_byte = b;
        bus.wr_valid = 1'b1;
        bus.wr_last = last;
        while (!bus.wr_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("ready_timeout", 32'(bus.wr_ready), 32'd1);
        tick();
        bus.wr_valid = 1'b0;
        bus.wr_last = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [15:0] exp);
        bus.lut_addr = a;
        #1;
        chk(name, 32'(bus.lut_out), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0;
        longint t1;
        bus.start = 1'b0;
        bus.wr_byte = '0;
        bus.wr_valid = 1'b0;
        bus.wr_last = 1'b0;
        bus.lut_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'(bus.wr_ready), 32'd0);
        chk("rst_done", 32'(bus.load_done), 32'd0);
        chk("rst_count", 32'(bus.load_count), 32'd0);
        chk("rst_busy", 32'(bus.load_busy), 32'd0);
        mon_en = 1'b1;

        // two-entry session ending on wr_last
        cnt_q.push_back(9'd2);
        pulse_start();
        chk("start_busy", 32'(bus.load_busy), 32'd1);
        chk("start_ready", 32'(bus.wr_ready), 32'd1);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b1);
        chk("short_done", 32'(bus.load_done), 32'd1);
        chk("short_count", 32'(bus.load_count), 32'd2);
        chk("short_ready", 32'(bus.wr_ready), 32'd0);
        chk("short_busy", 32'(bus.load_busy), 32'd0);
        rd("short_t0", 8'd0, 16'h1234);
        rd("short_t1", 8'd1, 16'hABCD);

        // full table, wr_last never asserted, back-to-back bytes
        cnt_q.push_back(9'd256);
        pulse_start();
        t0 = $time;
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 1'b0);
            send(~8'(i), 1'b0);
        end
        t1 = $time;
        chk("full_cycles", 32'((t1 - t0) / 10), 32'd512);
        chk("full_done", 32'(bus.load_done), 32'd1);
        chk("full_count", 32'(bus.load_count), 32'd256);
        rd("full_t255", 8'd255, 16'hFF00);
        rd("full_t0", 8'd0, 16'h00FF);
        rd("full_t128", 8'd128, 16'h807F);
        bus.wr_byte = 8'h99;
        bus.wr_valid = 1'b1;
        repeat (3) tick();
        bus.wr_valid = 1'b0;
        chk("extra_byte_count", 32'(bus.load_count), 32'd256);
        chk("extra_byte_ready", 32'(bus.wr_ready), 32'd0);
        rd("extra_byte_t0", 8'd0, 16'h00FF);

        // stalled session with garbage on wr_byte while wr_valid is low
        cnt_q.push_back(9'd4);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            for (int h = 0; h < 2; h++) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.wr_byte = 8'hEE;
                    tick();
                end
                send(h == 0 ? 8'hA0 + 8'(i) : 8'h50 + 8'(i), i == 3 && h == 1);
            end
        end
        chk("stall_count", 32'(bus.load_count), 32'd4);
        rd("stall_t0", 8'd0, 16'hA050);
        rd("stall_t1", 8'd1, 16'hA151);
        rd("stall_t2", 8'd2, 16'hA252);
        rd("stall_t3", 8'd3, 16'hA353);
        rd("stall_t4", 8'd4, 16'h04FB);

        // abort: start collides with an accepted lo byte
        cnt_q.push_back(9'd1);
        pulse_start();
        send(8'h55, 1'b0);
        bus.start = 1'b1;
        bus.wr_byte = 8'h66;
        bus.wr_valid = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.wr_valid = 1'b0;
        chk("abort_count", 32'(bus.load_count), 32'd0);
        chk("abort_busy", 32'(bus.load_busy), 32'd1);
        rd("abort_dropped", 8'd0, 16'hA050);
        send(8'h77, 1'b0);
        send(8'h88, 1'b1);
        rd("abort_t0", 8'd0, 16'h7788);
        rd("abort_t1_kept", 8'd1, 16'hA151);
        chk("abort_done_count", 32'(bus.load_count), 32'd1);

        // reset while a lo byte is being offered
        pulse_start();
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hD1, 1'b0);
        bus.wr_byte = 8'hD2;
        bus.wr_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.wr_valid = 1'b0;
        chk("rstmid_busy", 32'(bus.load_busy), 32'd0);
        chk("rstmid_ready", 32'(bus.wr_ready), 32'd0);
        chk("rstmid_done", 32'(bus.load_done), 32'd0);
        chk("rstmid_count", 32'(bus.load_count), 32'd0);
        rd("rstmid_t1_kept", 8'd1, 16'hA151);
        rd("rstmid_t0", 8'd0, 16'hC1C2);

        // read and write at the same address on the same edge
        cnt_q.push_back(9'd1);
        pulse_start();
        send(8'hE1, 1'b0);
        bus.lut_addr = 8'd0;
        bus.wr_byte = 8'hE2;
        bus.wr_valid = 1'b1;
        bus.wr_last = 1'b1;
        #1;
        chk("rw_old", 32'(bus.lut_out), 32'h0000C1C2);
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.wr_last = 1'b0;
        chk("rw_new", 32'(bus.lut_out), 32'h0000E1E2);

        repeat (2) tick();
        chk("queue_drained", 32'(cnt_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lut_loader.md
# lut_loader

Run-time writer for the 256-entry, 16-bit line-instruction LUT. It accepts a byte stream on a valid/ready handshake and packs byte pairs (high byte first) into 16-bit entries. Entries are written at auto-incrementing addresses, and the same table is exposed on a combinational read port for the fetch/decode path. It replaces file-initialised LUT contents, so programs can be swapped without resynthesis.

## Interface
- addr_w, 8, LUT address width; table depth is 2**addr_w
- data_w, 16, LUT entry width; must be 2× byte width
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a load session at address 0
- wr_byte  in  8  stream byte
- wr_valid  in  1  wr_byte is valid this cycle
- wr_last  in  1  qualifies the current byte as the final byte of the session; sampled only on an accepted low byte
- wr_ready  out  1  loader will accept a byte this cycle
- load_busy  out  1  session in progress
- load_done  out  1  session finished; held until the next start or reset
- load_count  out  addr_w+1  number of entries written in the current or last session
- lut_addr  in  addr_w  read address (program-counter side)
- lut_out  out  data_w  combinational read data, table[lut_addr]

## Operation
- FSM states: IDLE, LOAD_HI, LOAD_LO, DONE.
- IDLE: wr_ready=0. On start, go to LOAD_HI, clear the write pointer and load_count to 0, and clear load_done.
- LOAD_HI: wr_ready=1. An accepted byte (wr_valid&&wr_ready) is latched into the hi register. Go to LOAD_LO.
- LOAD_LO: wr_ready=1. An accepted byte writes table[ptr] <= {hi, wr_byte}, then ptr++ and load_count++.
  - If wr_last=1 or ptr==2**addr_w-1, go to DONE.
  - Otherwise go to LOAD_HI.
- DONE: wr_ready=0, load_done=1. start re-enters LOAD_HI, same as from IDLE.
- start while in LOAD_HI or LOAD_LO aborts the session:
  - ptr and load_count go to 0, next state is LOAD_HI, and any partial hi byte is discarded.
  - Entries already written stay in the table.
  - start has priority over a byte accepted in the same cycle; that byte is dropped.
- wr_last on a hi byte is ignored. A session always ends on a complete entry.
- Bytes presented while wr_ready=0 are ignored and never stall anything.
- load_busy = state is LOAD_HI or LOAD_LO.
- The read port is always live, including during a load. Entries not yet written hold their previous contents.
- load_count saturates by construction at 2**addr_w (= 256), which is why it is addr_w+1 bits wide.

## Timing
- Reset values:
  - state=IDLE, wr_ready=0, load_busy=0, load_done=0, load_count=0, ptr=0, hi=0.
  - Table contents are not cleared; lut_out is unaffected by reset.
- Reset mid-session returns to IDLE on the next edge. No further writes occur.
- The table write is synchronous on the LO-byte acceptance edge.
- lut_out is purely combinational from the table array and lut_addr.
  - If read and write hit the same address in the same cycle, lut_out shows old data until after the edge; the new data is visible the cycle after.
- Throughput: one byte per cycle, so one entry per 2 cycles with wr_valid held high.
- wr_ready is a registered function of state only and has no combinational path from wr_valid.
- load_done rises in the cycle after the final LO byte is accepted.

## Structure
- Shared package lut_pkg:
  - loader state enum (IDLE, LOAD_HI, LOAD_LO, DONE)
  - LUT_ADDR_W=8, LUT_DATA_W=16, BYTE_W=8
- Natural sub-module: lut_ram, a 2**addr_w × data_w array with one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
  - lut_loader holds the FSM, pointer, hi register and counters, and instantiates lut_ram.
- Target size is roughly 150–250 lines total.

## Test plan
- Reset, then check outputs: wr_ready=0, load_done=0, load_count=0, load_busy=0.
- start, then stream bytes 12,34,AB,CD with wr_last on CD. Expected:
  - table[0]=1234, table[1]=ABCD, load_count=2, load_done=1
  - wr_ready=0 afterwards
  - lut_addr=1 reads ABCD
- Full load: 512 bytes where entry i = {i,~i}, wr_last never asserted. Expected:
  - DONE after entry 255, load_count=256
  - table[255]=FF00
  - the 513th byte is ignored
- Stall: toggle wr_valid randomly during a 4-entry load. Contents must match the no-stall result, and no byte may be accepted while wr_valid=0.
- Abort: start, send hi byte 55, then start with wr_valid=1 and byte 66 in the same cycle. Expected:
  - 66 dropped, ptr=0
  - next pair 77,88 writes table[0]=7788
- Reset during LOAD_LO:
  - Expect IDLE next cycle and table[ptr] unchanged.
  - A read of a previously written entry must still return its old value.
  - A read at the entry being written during the write edge returns old data, then new data the following cycle.
